// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for both arbiter ports plus shared read data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata, busy
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way picker: round-robin on a preferred-port pointer, or fixed priority to port 0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       mode,
  output logic [1:0] gnt
);

  // ptr names the port that wins the next tie; mode=1 pins ties to port 0
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (mode || !ptr) gnt = 2'b01;
      else              gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto one synchronous RAM port and returns read data per port.
//
// state  | meaning
// IDLE   | sample requests, grant winner
// ACCESS | mem_enable high for this one cycle
// RDWAIT | read only: RAM is updating MBR_in
// RESP   | capture MBR_in into rdata, pulse owner's rvalid
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clock,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MBR_out,
  input  logic [DATA_W-1:0] MBR_in,
  output logic              mem_enable,
  output logic              mem_op
);

  arb_state_t state;
  logic       ptr;
  logic       owner;
  logic [1:0] pick;

  rr_arb2 u_pick (
    .req  ({bus.p1_req, bus.p0_req}),
    .ptr  (ptr),
    .mode (ARB_MODE == ARB_FIXED),
    .gnt  (pick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      MAR           <= '0;
      MBR_out       <= '0;
      mem_op        <= MEM_READ;
      mem_enable    <= 1'b0;
      bus.rdata     <= '0;
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      mem_enable    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            owner      <= pick[1];
            ptr        <= pick[0];  // the port not granted wins the next tie
            MAR        <= pick[1] ? bus.p1_addr  : bus.p0_addr;
            MBR_out    <= pick[1] ? bus.p1_wdata : bus.p0_wdata;
            mem_op     <= pick[1] ? bus.p1_we    : bus.p0_we;
            bus.p0_gnt <= pick[0];
            bus.p1_gnt <= pick[1];
            mem_enable <= 1'b1;
            bus.busy   <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_op == MEM_WRITE) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: state <= RESP;
        RESP: begin
          bus.rdata     <= MBR_in;
          bus.p0_rvalid <= ~owner;
          bus.p1_rvalid <= owner;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance u0 and fixed-priority instance u1.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  logic [31:0] mar0, mbr_out0, mbr_in0, mar1, mbr_out1, mbr_in1;
  logic        me0, op0, me1, op1;
  logic [31:0] ram0 [16];
  logic [31:0] ram1 [16];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) u0 (
    .clock(clock), .reset(reset), .bus(bus0), .MAR(mar0), .MBR_out(mbr_out0),
    .MBR_in(mbr_in0), .mem_enable(me0), .mem_op(op0)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) u1 (
    .clock(clock), .reset(reset), .bus(bus1), .MAR(mar1), .MBR_out(mbr_out1),
    .MBR_in(mbr_in1), .mem_enable(me1), .mem_op(op1)
  );

  // RAM models: act on the edge after mem_enable is seen high
  always @(posedge clock) begin
    if (me0) begin
      if (op0) ram0[mar0[3:0]] <= mbr_out0;
      else     mbr_in0 <= ram0[mar0[3:0]];
    end
    if (me1) begin
      if (op1) ram1[mar1[3:0]] <= mbr_out1;
      else     mbr_in1 <= ram1[mar1[3:0]];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input bit port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (!port) begin
      bus0.p0_req = req; bus0.p0_we = we; bus0.p0_addr = addr; bus0.p0_wdata = wdata;
    end else begin
      bus0.p1_req = req; bus0.p1_we = we; bus0.p1_addr = addr; bus0.p1_wdata = wdata;
    end
  endtask

  task automatic rd0(input bit port, input logic [31:0] addr, input logic [31:0] exp);
    set_req0(port, 1'b1, 1'b0, addr, 32'h0);
    step();
    chk("rd_gnt",   port ? bus0.p1_gnt : bus0.p0_gnt, 1);
    chk("rd_ogn",   port ? bus0.p0_gnt : bus0.p1_gnt, 0);
    chk("rd_me",    me0, 1);
    chk("rd_op",    op0, 0);
    chk("rd_mar",   mar0, addr);
    set_req0(port, 1'b0, 1'b0, addr, 32'h0);
    step();
    chk("rd_me_off", me0, 0);
    chk("rd_gnt_off", port ? bus0.p1_gnt : bus0.p0_gnt, 0);
    step();
    chk("rd_early_rv", bus0.p0_rvalid | bus0.p1_rvalid, 0);
    chk("rd_busy", bus0.busy, 1);
    step();
    chk("rd_rvalid", port ? bus0.p1_rvalid : bus0.p0_rvalid, 1);
    chk("rd_orv",    port ? bus0.p0_rvalid : bus0.p1_rvalid, 0);
    chk("rd_data",   bus0.rdata, exp);
    chk("rd_idle",   bus0.busy, 0);
    step();
    chk("rd_rv_off", bus0.p0_rvalid | bus0.p1_rvalid, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram0[i] = 32'h0;
      ram1[i] = 32'h0;
    end
    ram0[1] = 32'd5;  ram0[3] = 32'h33; ram0[4] = 32'h44;
    ram1[8] = 32'h80; ram1[9] = 32'h90;
    set_req0(0, 0, 0, 0, 0);
    set_req0(1, 0, 0, 0, 0);
    bus1.p0_req = 0; bus1.p0_we = 0; bus1.p0_addr = 0; bus1.p0_wdata = 0;
    bus1.p1_req = 0; bus1.p1_we = 0; bus1.p1_addr = 0; bus1.p1_wdata = 0;

    step(); step();
    chk("rst_busy", bus0.busy, 0);
    chk("rst_me",   me0, 0);
    chk("rst_mar",  mar0, 0);
    chk("rst_gnt",  {bus0.p0_gnt, bus0.p1_gnt, bus1.p0_gnt, bus1.p1_gnt}, 0);
    reset = 1'b1;
    step();

    // single read on port 0
    rd0(0, 32'd1, 32'd5);

    // port 1 write then read-back
    set_req0(1, 1'b1, 1'b1, 32'd2, 32'd20);
    step();
    chk("wr_gnt",  bus0.p1_gnt, 1);
    chk("wr_p0g",  bus0.p0_gnt, 0);
    chk("wr_op",   op0, 1);
    chk("wr_me",   me0, 1);
    chk("wr_mar",  mar0, 2);
    chk("wr_mbr",  mbr_out0, 20);
    chk("wr_busy", bus0.busy, 1);
    set_req0(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    chk("wr_me_off", me0, 0);
    chk("wr_idle",   bus0.busy, 0);
    chk("wr_ram",    ram0[2], 20);
    rd0(1, 32'd2, 32'd20);

    // round-robin contention: both hold read requests for four grants
    set_req0(0, 1'b1, 1'b0, 32'd3, 32'd0);
    set_req0(1, 1'b1, 1'b0, 32'd4, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_g0", bus0.p0_gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_g1", bus0.p1_gnt, (i % 2 == 1) ? 1 : 0);
      step(); step(); step();
      chk("rr_v0", bus0.p0_rvalid, (i % 2 == 0) ? 1 : 0);
      chk("rr_v1", bus0.p1_rvalid, (i % 2 == 1) ? 1 : 0);
      chk("rr_data", bus0.rdata, (i % 2 == 0) ? 32'h33 : 32'h44);
    end
    set_req0(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req0(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();

    // reset while the read sits in RDWAIT
    set_req0(0, 1'b1, 1'b0, 32'd1, 32'hAA);
    step();
    chk("mr_gnt", bus0.p0_gnt, 1);
    chk("mr_mbr", mbr_out0, 32'hAA);
    set_req0(0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("mr_mar",   mar0, 0);
    chk("mr_mbr0",  mbr_out0, 0);
    chk("mr_rdata", bus0.rdata, 0);
    chk("mr_op",    op0, 0);
    chk("mr_me",    me0, 0);
    chk("mr_gnt0",  bus0.p0_gnt | bus0.p1_gnt, 0);
    chk("mr_rv0",   bus0.p0_rvalid | bus0.p1_rvalid, 0);
    chk("mr_busy",  bus0.busy, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_rv", bus0.p0_rvalid | bus0.p1_rvalid, 0);
      chk("mr_stay_idle", bus0.busy, 0);
    end
    rd0(0, 32'd1, 32'd5);

    // back-to-back writes from port 0 with req held high
    set_req0(0, 1'b1, 1'b1, 32'd5, 32'h55);
    step();
    chk("bb_g1", bus0.p0_gnt, 1);
    chk("bb_a1", mar0, 5);
    set_req0(0, 1'b1, 1'b1, 32'd6, 32'h66);
    step();
    chk("bb_gap1", bus0.p0_gnt, 0);
    step();
    chk("bb_g2", bus0.p0_gnt, 1);
    chk("bb_a2", mar0, 6);
    chk("bb_d2", mbr_out0, 32'h66);
    set_req0(0, 1'b1, 1'b1, 32'd7, 32'h77);
    step();
    chk("bb_gap2", bus0.p0_gnt, 0);
    step();
    chk("bb_g3", bus0.p0_gnt, 1);
    chk("bb_a3", mar0, 7);
    set_req0(0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    chk("bb_ram5", ram0[5], 32'h55);
    chk("bb_ram6", ram0[6], 32'h66);
    chk("bb_ram7", ram0[7], 32'h77);
    chk("bb_idle", bus0.busy, 0);

    // fixed priority instance: port 0 wins until it drops req
    bus1.p0_req = 1; bus1.p0_addr = 32'd8;
    bus1.p1_req = 1; bus1.p1_addr = 32'd9;
    step();
    chk("fx_g0a", bus1.p0_gnt, 1);
    chk("fx_g1a", bus1.p1_gnt, 0);
    step(); step(); step();
    chk("fx_v0a", bus1.p0_rvalid, 1);
    chk("fx_da",  bus1.rdata, 32'h80);
    step();
    chk("fx_g0b", bus1.p0_gnt, 1);
    chk("fx_g1b", bus1.p1_gnt, 0);
    bus1.p0_req = 0;
    step(); step(); step();
    chk("fx_v0b", bus1.p0_rvalid, 1);
    chk("fx_v1b", bus1.p1_rvalid, 0);
    step();
    chk("fx_g1c", bus1.p1_gnt, 1);
    chk("fx_g0c", bus1.p0_gnt, 0);
    bus1.p1_req = 0;
    step(); step(); step();
    chk("fx_v1c", bus1.p1_rvalid, 1);
    chk("fx_v0c", bus1.p0_rvalid, 0);
    chk("fx_dc",  bus1.rdata, 32'h90);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
